// File: rtl/return_stack.sv
// LIFO of subroutine return addresses; top is combinational (zero latency), writes land next edge.
// No backpressure: push when full is dropped (sticky overflow), pop when empty is ignored (sticky underflow).
module return_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_nxt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             ovf_set;
  logic             unf_set;

  assign count   = sp;
  assign empty   = (sp == '0);
  assign full    = (sp == CW'(DEPTH));
  assign top_idx = AW'(sp - CW'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = AW'(sp);
    sp_nxt  = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en  = 1'b1;
          sp_nxt = sp + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_nxt = sp - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        // Call-and-return in one cycle: overwrite the top in place, never flagged.
        wr_en = 1'b1;
        if (!empty) begin
          wr_idx = top_idx;
        end else begin
          sp_nxt = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp <= sp_nxt;
      if (ovf_set) overflow <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  // Entries are not cleared by reset, but reset still suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_idx] <= d;
  end

endmodule

// File: tb/tb_return_stack.sv
// Directed and randomized checks of return_stack against hand-computed values and a queue model.
module tb_return_stack;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [9:0] d;
  logic [9:0] top;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  return_stack #(.WIDTH(10), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d),
    .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [9:0] dv);
    push = p;
    pop  = q;
    d    = dv;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 10'h000);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic push_one(input logic [9:0] dv);
    drive(1'b1, 1'b0, dv);
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (top !== 10'h000) begin failures++; $display("FAIL reset_top got=%h exp=000", top); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push_one(10'h005);
    push_one(10'h012);
    push_one(10'h3FF);
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL pp_count got=%0d exp=3", count); end
    checks++; if (top !== 10'h3FF) begin failures++; $display("FAIL pp_top got=%h exp=3ff", top); end
    drive(1'b0, 1'b1, 10'h000);
    checks++; if (top !== 10'h3FF) begin failures++; $display("FAIL pp_pop1_top got=%h exp=3ff", top); end
    tick();
    checks++; if (top !== 10'h012) begin failures++; $display("FAIL pp_pop2_top got=%h exp=012", top); end
    tick();
    checks++; if (top !== 10'h005) begin failures++; $display("FAIL pp_pop3_top got=%h exp=005", top); end
    tick();
    idle();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pp_empty got=%b exp=1", empty); end
    checks++; if (top !== 10'h000) begin failures++; $display("FAIL pp_end_top got=%h exp=000", top); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL pp_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) push_one(10'(i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full_pre got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_pre got=%b exp=0", overflow); end
    push_one(10'h0AA);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (top !== 10'h008) begin failures++; $display("FAIL ovf_top got=%h exp=008", top); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    drive(1'b0, 1'b1, 10'h000);
    tick();
    idle();
    checks++; if (top !== 10'h007) begin failures++; $display("FAIL ovf_pop_top got=%h exp=007", top); end
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL ovf_pop_count got=%0d exp=7", count); end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b0, 1'b1, 10'h000);
    tick();
    idle();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
    checks++; if (top !== 10'h000) begin failures++; $display("FAIL unf_top got=%h exp=000", top); end
    push_one(10'h055);
    checks++; if (top !== 10'h055) begin failures++; $display("FAIL unf_push_top got=%h exp=055", top); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL unf_push_count got=%0d exp=1", count); end
  endtask

  task automatic test_replace();
    do_reset();
    push_one(10'h010);
    push_one(10'h020);
    drive(1'b1, 1'b1, 10'h030);
    tick();
    idle();
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL rep_count got=%0d exp=2", count); end
    checks++; if (top !== 10'h030) begin failures++; $display("FAIL rep_top got=%h exp=030", top); end
    drive(1'b0, 1'b1, 10'h000);
    tick();
    idle();
    checks++; if (top !== 10'h010) begin failures++; $display("FAIL rep_pop_top got=%h exp=010", top); end
    // replace while full must not raise overflow
    do_reset();
    for (int i = 1; i <= 8; i++) push_one(10'(i + 16));
    drive(1'b1, 1'b1, 10'h1BB);
    tick();
    idle();
    checks++; if (top !== 10'h1BB) begin failures++; $display("FAIL rep_full_top got=%h exp=1bb", top); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL rep_full_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rep_full_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    push_one(10'h001);
    push_one(10'h002);
    push_one(10'h003);
    drive(1'b0, 1'b1, 10'h000);
    tick();
    tick();
    tick();
    tick();
    idle();
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL rp_pre_unf got=%b exp=1", underflow); end
    drive(1'b1, 1'b0, 10'h3EE);
    push_one(10'h004);
    drive(1'b1, 1'b0, 10'h3EE);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rp_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rp_empty got=%b exp=1", empty); end
    checks++; if (top !== 10'h000) begin failures++; $display("FAIL rp_top got=%h exp=000", top); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL rp_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_random();
    logic [9:0] model[$];
    logic       m_ovf;
    logic       m_unf;
    logic [9:0] exp_top;
    logic       p;
    logic       q;
    logic [9:0] dv;
    do_reset();
    drive(1'b1, 1'b1, 10'h07F);
    tick();
    idle();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL pe_count got=%0d exp=1", count); end
    checks++; if (top !== 10'h07F) begin failures++; $display("FAIL pe_top got=%h exp=07f", top); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL pe_flags got=%b exp=00", {overflow, underflow}); end
    model.push_back(10'h07F);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int n = 0; n < 300; n++) begin
      p  = 1'($urandom_range(0, 1));
      q  = 1'($urandom_range(0, 1));
      dv = 10'($urandom);
      drive(p, q, dv);
      exp_top = (model.size() == 0) ? 10'h000 : model[model.size() - 1];
      checks++; if (top !== exp_top) begin failures++; $display("FAIL rnd_top n=%0d got=%h exp=%h", n, top, exp_top); end
      case ({p, q})
        2'b10: if (model.size() < 8) model.push_back(dv); else m_ovf = 1'b1;
        2'b01: if (model.size() > 0) void'(model.pop_back()); else m_unf = 1'b1;
        2'b11: if (model.size() > 0) model[model.size() - 1] = dv; else model.push_back(dv);
        default: ;
      endcase
      tick();
      checks++; if (count !== 4'(model.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, model.size()); end
      checks++; if ({full, empty} !== {model.size() == 8, model.size() == 0}) begin failures++; $display("FAIL rnd_fe n=%0d got=%b%b size=%0d", n, full, empty, model.size()); end
      checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {overflow, underflow}, {m_ovf, m_unf}); end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    d     = 10'h000;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
